// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared datapath, with a memory ready handshake, illegal-opcode trap and saturating counters.
module mips_multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter bit ADDI_EN = 1'b1
) (
    input  logic             clk,
    input  logic             R,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state_out,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0]       OP_RTYPE = 6'b000000;
    localparam logic [5:0]       OP_LW    = 6'b100011;
    localparam logic [5:0]       OP_SW    = 6'b101011;
    localparam logic [5:0]       OP_BEQ   = 6'b000100;
    localparam logic [5:0]       OP_J     = 6'b000010;
    localparam logic [5:0]       OP_ADDI  = 6'b001000;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = ADDI_EN ? S_ADDIEX : S_TRAP;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_EXEC:   w_next = S_RWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_state     <= S_FETCH;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_cycle_cnt != CNT_MAX) r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
            if (w_retire && (r_instr_cnt != CNT_MAX)) r_instr_cnt <= r_instr_cnt + CNT_ONE;
        end
    end

    // Decoded from the state register; only the FETCH strobes follow mem_ready.
    // Everything is forced low while reset is held, independent of the encoding.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegal     = 1'b0;
        if (R) begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: ALUSrcB = 2'b11;
                S_MEMADR, S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_ADDIWB: RegWrite = 1'b1;
                S_TRAP:   illegal = 1'b1;
                default:  illegal = 1'b0;
            endcase
        end
    end

    assign state_out = r_state;
    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: a per-cycle vector table through a mixed instruction stream,
// then trap hold, asynchronous reset, and a narrow-counter instance with addi disabled.
module tb_mips_multicycle_ctrl;

    // Control bundle order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst
    //                       RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0]
    localparam logic [15:0] C_FETCH   = 16'h1010;
    localparam logic [15:0] C_FETCH_R = 16'h9410;
    localparam logic [15:0] C_DECODE  = 16'h0030;
    localparam logic [15:0] C_MEMADR  = 16'h0060;
    localparam logic [15:0] C_MEMRD   = 16'h3000;
    localparam logic [15:0] C_MEMWB   = 16'h0280;
    localparam logic [15:0] C_MEMWR   = 16'h2800;
    localparam logic [15:0] C_EXEC    = 16'h0048;
    localparam logic [15:0] C_RWB     = 16'h0180;
    localparam logic [15:0] C_BRANCH  = 16'h4045;
    localparam logic [15:0] C_JUMP    = 16'h8002;
    localparam logic [15:0] C_ADDIWB  = 16'h0080;

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        ill;
        int          ic;
    } vec_t;

    logic        clk = 1'b0;
    logic        r_n, r2_n;
    logic [5:0]  op, op2;
    logic        mr, mr2;

    logic        pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0]  asb, aop, pcs;
    logic [3:0]  st;
    logic        ill;
    logic [31:0] cyc, ic;

    logic        pcw2, pcwc2, iord2, mrd2, mwr2, irw2, m2r2, rdst2, rw2, asa2;
    logic [1:0]  asb2, aop2, pcs2;
    logic [3:0]  st2;
    logic        ill2;
    logic [3:0]  cyc2, ic2;

    logic [15:0] ctrl, ctrl2;
    assign ctrl  = {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs};
    assign ctrl2 = {pcw2, pcwc2, iord2, mrd2, mwr2, irw2, m2r2, rdst2, rw2, asa2, asb2, aop2, pcs2};

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[36];

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .R(r_n), .opcode(op), .mem_ready(mr),
        .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mrd), .MemWrite(mwr),
        .IRWrite(irw), .MemtoReg(m2r), .RegDst(rdst), .RegWrite(rw), .ALUSrcA(asa),
        .ALUSrcB(asb), .ALUOp(aop), .PCSource(pcs), .state_out(st), .illegal(ill),
        .cycle_cnt(cyc), .instr_cnt(ic)
    );

    mips_multicycle_ctrl #(.CNT_W(4), .ADDI_EN(1'b0)) dut2 (
        .clk(clk), .R(r2_n), .opcode(op2), .mem_ready(mr2),
        .PCWrite(pcw2), .PCWriteCond(pcwc2), .IorD(iord2), .MemRead(mrd2), .MemWrite(mwr2),
        .IRWrite(irw2), .MemtoReg(m2r2), .RegDst(rdst2), .RegWrite(rw2), .ALUSrcA(asa2),
        .ALUSrcB(asb2), .ALUOp(aop2), .PCSource(pcs2), .state_out(st2), .illegal(ill2),
        .cycle_cnt(cyc2), .instr_cnt(ic2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] o, input logic m, input logic [3:0] s,
                                input logic [15:0] c, input logic il, input int n);
        vec_t v;
        v.op = o; v.mr = m; v.st = s; v.ctrl = c; v.ill = il; v.ic = n;
        return v;
    endfunction

    initial begin
        // R-type, then lw with 2 fetch stalls and 3 MEMRD stalls
        vecs[0]  = mk(6'h00, 1, 0,  C_FETCH_R, 0, 0);
        vecs[1]  = mk(6'h00, 1, 1,  C_DECODE,  0, 0);
        vecs[2]  = mk(6'h00, 1, 6,  C_EXEC,    0, 0);
        vecs[3]  = mk(6'h00, 1, 7,  C_RWB,     0, 0);
        vecs[4]  = mk(6'h23, 0, 0,  C_FETCH,   0, 1);
        vecs[5]  = mk(6'h23, 0, 0,  C_FETCH,   0, 1);
        vecs[6]  = mk(6'h23, 1, 0,  C_FETCH_R, 0, 1);
        vecs[7]  = mk(6'h23, 1, 1,  C_DECODE,  0, 1);
        vecs[8]  = mk(6'h23, 1, 2,  C_MEMADR,  0, 1);
        vecs[9]  = mk(6'h23, 0, 3,  C_MEMRD,   0, 1);
        vecs[10] = mk(6'h23, 0, 3,  C_MEMRD,   0, 1);
        vecs[11] = mk(6'h23, 0, 3,  C_MEMRD,   0, 1);
        vecs[12] = mk(6'h23, 1, 3,  C_MEMRD,   0, 1);
        vecs[13] = mk(6'h23, 1, 4,  C_MEMWB,   0, 1);
        // beq (mem_ready low where it must be ignored), j, sw, addi
        vecs[14] = mk(6'h04, 1, 0,  C_FETCH_R, 0, 2);
        vecs[15] = mk(6'h04, 0, 1,  C_DECODE,  0, 2);
        vecs[16] = mk(6'h04, 0, 8,  C_BRANCH,  0, 2);
        vecs[17] = mk(6'h02, 1, 0,  C_FETCH_R, 0, 3);
        vecs[18] = mk(6'h02, 1, 1,  C_DECODE,  0, 3);
        vecs[19] = mk(6'h02, 1, 9,  C_JUMP,    0, 3);
        vecs[20] = mk(6'h2B, 1, 0,  C_FETCH_R, 0, 4);
        vecs[21] = mk(6'h2B, 1, 1,  C_DECODE,  0, 4);
        vecs[22] = mk(6'h2B, 1, 2,  C_MEMADR,  0, 4);
        vecs[23] = mk(6'h2B, 1, 5,  C_MEMWR,   0, 4);
        vecs[24] = mk(6'h08, 1, 0,  C_FETCH_R, 0, 5);
        vecs[25] = mk(6'h08, 1, 1,  C_DECODE,  0, 5);
        vecs[26] = mk(6'h08, 1, 10, C_MEMADR,  0, 5);
        vecs[27] = mk(6'h08, 1, 11, C_ADDIWB,  0, 5);
        // sw with one MEMWR stall, then an illegal opcode
        vecs[28] = mk(6'h2B, 1, 0,  C_FETCH_R, 0, 6);
        vecs[29] = mk(6'h2B, 1, 1,  C_DECODE,  0, 6);
        vecs[30] = mk(6'h2B, 1, 2,  C_MEMADR,  0, 6);
        vecs[31] = mk(6'h2B, 0, 5,  C_MEMWR,   0, 6);
        vecs[32] = mk(6'h2B, 1, 5,  C_MEMWR,   0, 6);
        vecs[33] = mk(6'h3F, 1, 0,  C_FETCH_R, 0, 7);
        vecs[34] = mk(6'h3F, 1, 1,  C_DECODE,  0, 7);
        vecs[35] = mk(6'h3F, 1, 12, 16'h0000,  1, 7);

        r_n = 1'b0; r2_n = 1'b0;
        op = 6'h00; op2 = 6'h00; mr = 1'b1; mr2 = 1'b1;
        #1;
        chk("rst_ctrl", {16'h0, ctrl}, 32'h0);
        chk("rst_state", {28'h0, st}, 32'h0);
        chk("rst_cycle", cyc, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_held_state", {28'h0, st}, 32'h0);
        chk("rst_held_ctrl", {16'h0, ctrl}, 32'h0);
        r_n = 1'b1;

        for (int i = 0; i < 36; i++) begin
            op = vecs[i].op;
            mr = vecs[i].mr;
            #1;
            chk($sformatf("v%0d_state", i), {28'h0, st}, {28'h0, vecs[i].st});
            chk($sformatf("v%0d_ctrl", i), {16'h0, ctrl}, {16'h0, vecs[i].ctrl});
            chk($sformatf("v%0d_illegal", i), {31'h0, ill}, {31'h0, vecs[i].ill});
            chk($sformatf("v%0d_instr", i), ic, vecs[i].ic);
            chk($sformatf("v%0d_cycle", i), cyc, i);
            @(negedge clk);
        end

        // Trap is absorbing whatever the inputs do
        for (int k = 0; k < 20; k++) begin
            op = 6'h00;
            mr = k[0];
            #1;
            chk($sformatf("trap%0d_state", k), {28'h0, st}, 32'd12);
            chk($sformatf("trap%0d_illegal", k), {31'h0, ill}, 32'd1);
            chk($sformatf("trap%0d_ctrl", k), {16'h0, ctrl}, 32'h0);
            chk($sformatf("trap%0d_instr", k), ic, 32'd7);
            chk($sformatf("trap%0d_cycle", k), cyc, 36 + k);
            @(negedge clk);
        end

        // Asynchronous clear of the trap, no clock edge in between
        #2 r_n = 1'b0;
        #1;
        chk("trap_clr_state", {28'h0, st}, 32'h0);
        chk("trap_clr_illegal", {31'h0, ill}, 32'h0);
        chk("trap_clr_ctrl", {16'h0, ctrl}, 32'h0);
        chk("trap_clr_cycle", cyc, 32'h0);
        chk("trap_clr_instr", ic, 32'h0);
        @(negedge clk);

        // Reset asserted in the middle of a stalled MEMWR
        r_n = 1'b1; op = 6'h2B; mr = 1'b1;
        #1 chk("mw_fetch_ctrl", {16'h0, ctrl}, {16'h0, C_FETCH_R});
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mr = 1'b0;
        #1;
        chk("mw_state", {28'h0, st}, 32'd5);
        chk("mw_ctrl", {16'h0, ctrl}, {16'h0, C_MEMWR});
        chk("mw_cycle", cyc, 32'd3);
        #2 r_n = 1'b0;
        #1;
        chk("mw_rst_ctrl", {16'h0, ctrl}, 32'h0);
        chk("mw_rst_state", {28'h0, st}, 32'h0);
        chk("mw_rst_cycle", cyc, 32'h0);
        chk("mw_rst_instr", ic, 32'h0);
        @(negedge clk);
        r_n = 1'b1; mr = 1'b1;
        #1 chk("mw_after_instr", ic, 32'h0);

        // Narrow counters, addi disabled: addi must trap and cycle_cnt must saturate at 15
        @(negedge clk);
        r2_n = 1'b1; op2 = 6'h08; mr2 = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            #1;
            chk($sformatf("n%0d_cycle", k), {28'h0, cyc2}, (k > 15) ? 32'd15 : k);
            chk($sformatf("n%0d_instr", k), {28'h0, ic2}, 32'h0);
            if (k == 1) chk("n_decode_state", {28'h0, st2}, 32'd1);
            if (k >= 2) begin
                chk($sformatf("n%0d_state", k), {28'h0, st2}, 32'd12);
                chk($sformatf("n%0d_illegal", k), {31'h0, ill2}, 32'd1);
                chk($sformatf("n%0d_ctrl", k), {16'h0, ctrl2}, 32'h0);
            end
            @(negedge clk);
        end
        #2 r2_n = 1'b0;
        #1;
        chk("n_clr_illegal", {31'h0, ill2}, 32'h0);
        chk("n_clr_state", {28'h0, st2}, 32'h0);
        chk("n_clr_cycle", {28'h0, cyc2}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle MIPS control unit with an FSM that replaces the single-cycle combinational control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB steps over a shared datapath and one unified memory.
- Adds a memory ready handshake for variable-latency memory, an illegal-opcode trap, and saturating cycle/instruction counters.

Parameters:
- CNT_W, 32, width of the cycle_cnt and instr_cnt counters.
- ADDI_EN, 1, when 1 addi (opcode 001000) is executed; when 0 addi traps as illegal.

Ports:
- clk  in  1  system clock, rising edge
- R  in  1  reset, asynchronous, active-low
- opcode  in  6  IR[31:26] from datapath; sampled in DECODE
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero (beq)
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  load instruction register
- MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR
- RegDst  out  1  destination register: 0=rt, 1=rd
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=rs
- ALUSrcB  out  2  00=rt, 01=const 4, 10=signext, 11=signext<<2
- ALUOp  out  2  00=add, 01=sub, 10=funct field
- PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
- state_out  out  4  current state encoding
- illegal  out  1  trap flag
- cycle_cnt  out  CNT_W  cycles since reset
- instr_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (R=0, asynchronous):
  - state=FETCH(0); cycle_cnt=0, instr_cnt=0, illegal=0.
  - All control outputs are 0, regardless of the state encoding, while R=0.
  - Reset mid-instruction abandons the instruction with no retire count.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=12.
- Outputs are Moore except the mem_ready-gated strobes; any output not listed for a state is 0.
- FETCH:
  - Always: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1; then go to DECODE. Otherwise hold in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX if ADDI_EN, else TRAP
  - any other opcode -> TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD for lw, MEMWR for sw. Opcode is held stable by the IR.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Then FETCH; retire.
- MEMWR: MemWrite=1, IorD=1. Hold until mem_ready=1, then FETCH; retire in the mem_ready cycle.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Then RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Then FETCH; retire.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Then FETCH; retire.
- JUMP: PCWrite=1, PCSource=10. Then FETCH; retire.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Then ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Then FETCH; retire.
- TRAP:
  - illegal=1, all control outputs 0, absorbing state; exit only by reset.
  - cycle_cnt keeps counting; instr_cnt frozen.
- Retire: instr_cnt += 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP or ADDIWB.
- cycle_cnt increments every clock with R=1.
- Both counters saturate at 2^CNT_W-1; they never wrap.
- Instruction latency with mem_ready always 1:
  - lw = 5 cycles
  - sw, R-type, addi = 4 cycles
  - beq, j = 3 cycles
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in all other states.

Test Plan:
- Reset then R-type with mem_ready=1: states 0,1,6,7,0. RWB shows RegWrite=1, RegDst=1. instr_cnt=1 after cycle 4.
- lw with mem_ready low 3 cycles in MEMRD: MEMRD held 4 cycles, MemRead=1, IorD=1. Total 8 cycles; MEMWB shows MemtoReg=1.
- FETCH with mem_ready=0 for 2 cycles: IRWrite and PCWrite stay 0 until the 3rd cycle, then pulse exactly 1 cycle.
- Sequence beq, j, sw, addi (ADDI_EN=1): 3+3+4+4=14 cycles, instr_cnt=4. BRANCH shows ALUOp=01, PCWriteCond=1; JUMP shows PCSource=10.
- opcode 111111, or addi with ADDI_EN=0: DECODE->TRAP, illegal=1 held 20 cycles, instr_cnt unchanged, cycle_cnt advances. R=0 clears the trap asynchronously.
- CNT_W=4: after 20 clocks cycle_cnt=15 (saturated). Reset asserted mid-MEMWR: outputs 0 immediately, state=0, counters=0.
